// File: rtl/sram_like_arbiter.sv
// Two-master, one-slave arbiter for the sram-like cache-side bus.
// Data has fixed priority over inst; a starvation counter forces an inst win after repeated losses.
module sram_like_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 owner, owner_nxt;
    logic [CNT_WIDTH-1:0] starve_cnt, starve_nxt;

    logic any_req, both_req, winner, sel, req_raw;

    // NOTE: every variable gets a default at the top so no latch is inferred.
    always_comb begin
        any_req  = inst_req | data_req;
        both_req = inst_req & data_req;
        winner   = data_req;
        if (both_req) begin
            winner = (starve_cnt < CNT_WIDTH'(STARVE_LIMIT));
        end

        // Winner drives the bus combinationally in IDLE; afterwards the locked owner does.
        sel = ((state == IDLE) && any_req) ? winner : owner;

        req_raw    = 1'b0;
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;

        case (state)
            IDLE: begin
                req_raw = any_req;
                if (any_req) begin
                    owner_nxt = winner;
                    state_nxt = bus_addr_ok ? WAIT : ADDR;
                    if (both_req && winner) begin
                        if (starve_cnt != '1) begin
                            starve_nxt = starve_cnt + CNT_WIDTH'(1);
                        end
                    end else if (inst_req && !winner) begin
                        starve_nxt = '0;
                    end
                end
            end
            ADDR: begin
                req_raw = owner ? data_req : inst_req;
                if (bus_addr_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    assign bus_req   = resetn & req_raw;
    assign grant     = resetn & sel;
    assign bus_wr    = sel ? data_wr    : inst_wr;
    assign bus_size  = sel ? data_size  : inst_size;
    assign bus_addr  = sel ? data_addr  : inst_addr;
    assign bus_wdata = sel ? data_wdata : inst_wdata;

    assign inst_addr_ok = bus_req & bus_addr_ok & ~grant;
    assign data_addr_ok = bus_req & bus_addr_ok & grant;

    // A completion outside WAIT is a bridge protocol error and is dropped here.
    assign inst_data_ok = resetn & (state == WAIT) & bus_data_ok & ~owner;
    assign data_data_ok = resetn & (state == WAIT) & bus_data_ok & owner;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;
    assign busy       = resetn & (state != IDLE);

endmodule
